// File: rtl/code_dec_pkg.sv
// Shared types and constants for the code decoder/display block.
// Holds the display FSM states and the seven-segment table used when CODE_DEC_SEG_EN is defined.
package code_dec_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Active-low g..a patterns, indexed by code (entry 7 is the leftmost element).
  localparam logic [7:0][6:0] SEG_TABLE = {
    7'b1111000,
    7'b0000010,
    7'b0010010,
    7'b0011001,
    7'b0110000,
    7'b0100100,
    7'b1111001,
    7'b1000000
  };

  function automatic logic [6:0] seg_of(input logic [2:0] code);
    return SEG_TABLE[code];
  endfunction

endpackage

// File: rtl/code_fifo.sv
// Small code FIFO for the decoder/display block.
// Uses pointers one bit wider than the address so that full and empty can be told apart.
module code_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/code_dec_disp.sv
// Queues 3-bit codes and shows each as a one-hot led pattern for HOLD_CYCLES enabled cycles.
// Define CODE_DEC_SEG_EN to add the registered seven-segment output out_hex0.
module code_dec_disp
  import code_dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int DEPTH       = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  input  logic       en,
  output logic [7:0] led,
  output logic       busy
`ifdef CODE_DEC_SEG_EN
  ,
  output logic [6:0] out_hex0
`endif
);

  state_t     state;
  state_t     state_n;
  logic [7:0] cnt;
  logic [7:0] cnt_n;
  logic [2:0] cur_code;
  logic [2:0] code_n;
  logic [7:0] led_n;
  logic       pop;
  logic [2:0] head;
  logic       fifo_full;
  logic       fifo_empty;

  assign in_ready = !fifo_full;
  assign busy     = (state == SHOW);

  code_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (3)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data (in_code),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Next-state logic: a code leaves the FIFO only when the display is idle or the current hold expires.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    code_n  = cur_code;
    pop     = 1'b0;
    if (en) begin
      unique case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            code_n  = head;
            cnt_n   = 8'(HOLD_CYCLES - 1);
            state_n = SHOW;
          end
        end
        SHOW: begin
          if (cnt != 8'd0) begin
            cnt_n = cnt - 8'd1;
          end else if (!fifo_empty) begin
            pop    = 1'b1;
            code_n = head;
            cnt_n  = 8'(HOLD_CYCLES - 1);
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    led_n = (state_n == SHOW) ? (8'b1 << code_n) : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      cur_code <= 3'd0;
      led      <= 8'h00;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cur_code <= code_n;
      led      <= led_n;
    end
  end

`ifdef CODE_DEC_SEG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_hex0 <= SEG_BLANK;
    end else begin
      out_hex0 <= (state_n == SHOW) ? seg_of(code_n) : SEG_BLANK;
    end
  end
`endif

endmodule

// File: tb/tb_code_dec_disp.sv
// Self-checking bench for code_dec_disp: directed scenarios plus random traffic against a queue model.
// Checks out_hex0 as well when CODE_DEC_SEG_EN is defined.
module tb_code_dec_disp;

  localparam int HOLD  = 4;
  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic       en;
  logic [7:0] led;
  logic       busy;
`ifdef CODE_DEC_SEG_EN
  logic [6:0] out_hex0;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: queued codes, the code on display and its remaining enabled cycles.
  int q[$];
  bit showing;
  int cur;
  int remaining;

  logic [6:0] seg_ref [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

  code_dec_disp #(
    .HOLD_CYCLES (HOLD),
    .DEPTH       (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_code  (in_code),
    .in_ready (in_ready),
    .en       (en),
    .led      (led),
    .busy     (busy)
`ifdef CODE_DEC_SEG_EN
    ,
    .out_hex0 (out_hex0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    showing   = 1'b0;
    cur       = 0;
    remaining = 0;
  endtask

  task automatic model_edge(input bit v, input int c, input bit e);
    bit was_full;
    was_full = (q.size() == DEPTH);
    if (e) begin
      if (showing) begin
        remaining--;
        if (remaining == 0) showing = 1'b0;
      end
      if (!showing && q.size() > 0) begin
        cur       = q.pop_front();
        showing   = 1'b1;
        remaining = HOLD;
      end
    end
    if (v && !was_full) q.push_back(c);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".led"}, 32'(led), showing ? (32'd1 << cur) : 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'(showing));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
`ifdef CODE_DEC_SEG_EN
    check({tag, ".hex"}, 32'(out_hex0), showing ? 32'(seg_ref[cur]) : 32'h7f);
`endif
  endtask

  // One clock: drive at the falling edge, let the rising edge happen, check at the next falling edge.
  task automatic step(input string tag, input bit v, input int c, input bit e);
    in_valid = v;
    in_code  = 3'(c);
    en       = e;
    model_edge(v, c, e);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_code  = 3'd0;
    en       = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single code 5 held for HOLD cycles then idle.
    step("single", 1'b1, 5, 1'b1);
    repeat (HOLD + 2) step("single", 1'b0, 0, 1'b1);

    // Three consecutive codes displayed back-to-back.
    step("b2b", 1'b1, 3, 1'b1);
    step("b2b", 1'b1, 0, 1'b1);
    step("b2b", 1'b1, 7, 1'b1);
    repeat (3 * HOLD + 2) step("b2b", 1'b0, 0, 1'b1);

    // Fill the FIFO while frozen; the fifth push is refused.
    step("fill", 1'b1, 1, 1'b0);
    step("fill", 1'b1, 6, 1'b0);
    step("fill", 1'b1, 2, 1'b0);
    step("fill", 1'b1, 4, 1'b0);
    step("fill", 1'b1, 7, 1'b0);
    check("fill.refused", 32'(in_ready), 32'd0);
    repeat (4 * HOLD + 2) step("drain", 1'b0, 0, 1'b1);

    // Freeze for three cycles in the middle of the second code.
    step("freeze", 1'b1, 1, 1'b1);
    step("freeze", 1'b1, 2, 1'b1);
    step("freeze", 1'b1, 3, 1'b1);
    repeat (HOLD) step("freeze", 1'b0, 0, 1'b1);
    repeat (3) step("freeze.off", 1'b0, 0, 1'b0);
    repeat (2 * HOLD + 2) step("freeze", 1'b0, 0, 1'b1);

    // Asynchronous reset while showing with two codes still queued.
    step("rst", 1'b1, 6, 1'b1);
    step("rst", 1'b1, 1, 1'b1);
    step("rst", 1'b1, 2, 1'b1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    model_reset();
    #1;
    check("rst.async_led", 32'(led), 32'd0);
    check("rst.async_busy", 32'(busy), 32'd0);
    check_all("rst.async");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (HOLD + 4) step("rst.after", 1'b0, 0, 1'b1);

    // Every code once, spaced so each display slot is filled back-to-back.
    for (int i = 0; i < 8; i++) begin
      step("allcodes", 1'b1, i, 1'b1);
      repeat (HOLD - 1) step("allcodes", 1'b0, 0, 1'b1);
    end
    repeat (HOLD + 2) step("allcodes", 1'b0, 0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0));
    end
    repeat (4 * HOLD + 4) step("flush", 1'b0, 0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/code_dec_disp.md
CODE_DEC_DISP -- requirements
Module: code_dec_disp

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: cycles each accepted code is displayed, legal range 1..255.
REQ-002 SHALL have parameter DEPTH, default 4: code FIFO entries, a power of two, at least 2.
REQ-003 SHALL provide clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL provide rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL provide in_valid  input  1  producer presents a code.
REQ-006 SHALL provide in_code  input  3  binary code 0..7 to decode.
REQ-007 SHALL provide in_ready  output  1  block can accept a code this cycle.
REQ-008 SHALL provide en  input  1  display advance enable.
REQ-009 SHALL provide led  output  8  registered one-hot decode of the displayed code, or all zeros.
REQ-010 SHALL provide busy  output  1  high while a code is being displayed.
REQ-011 SHALL provide out_hex0  output  7  active-low seven-segment pattern, bit order g..a, present only under CODE_DEC_SEG_EN.

Function
REQ-012 SHALL accept a code on a rising edge where in_valid and in_ready are both high, and push it into the FIFO.
REQ-013 SHALL drive in_ready = !fifo_full combinationally; a full FIFO refuses a push even when a pop occurs in the same cycle.
REQ-014 SHALL implement FSM states IDLE (led = 0, busy = 0) and SHOW (led = 1 << cur_code, busy = 1).
REQ-015 IDLE -> SHOW SHALL occur when en = 1 and the FIFO is non-empty: pop the head, load cur_code, and set cnt = HOLD_CYCLES-1; led is visible on the edge after the push at the earliest.
REQ-016 In SHOW with en = 1, cnt SHALL decrement each cycle while non-zero.
REQ-017 In SHOW at cnt == 0 with en = 1: if the FIFO is non-empty, SHALL pop and load the next code back-to-back with no zero gap; otherwise SHALL return to IDLE with led = 0.
REQ-018 Each code SHALL therefore occupy led for exactly HOLD_CYCLES enabled cycles; HOLD_CYCLES = 1 gives one code per cycle.
REQ-019 With en = 0, SHALL freeze cnt, state, and led and perform no pops; pushes remain permitted.
REQ-020 SHALL display codes in strict FIFO order with no loss or duplication; the write and read pointers wrap modulo DEPTH.
REQ-021 SHALL allow a push and a pop in the same cycle when the FIFO is neither full nor empty, leaving the occupancy unchanged.

Reset
REQ-022 While rst_n = 0, SHALL immediately force: state IDLE, FIFO empty (pointers 0), cnt 0, led 8'h00, busy 0, out_hex0 7'b1111111.
REQ-023 Reset asserted mid-SHOW SHALL discard the displayed code and all queued codes; in_ready SHALL be 1 after release.

Configuration
REQ-024 With macro CODE_DEC_SEG_EN defined, out_hex0 SHALL be registered alongside led and encode cur_code as follows (g..a):
- 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
- 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
- blank (1111111) in IDLE
REQ-025 Without CODE_DEC_SEG_EN, the out_hex0 port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Package code_dec_pkg SHALL hold the FSM state enum, the 8-entry segment constant table, and SEG_BLANK.
REQ-027 SHALL instantiate one sub-module, code_fifo (parameter DEPTH, width 3, push/pop/full/empty), with the FSM and decode kept in the top.

Verification
REQ-028 Reset, then push code 5 with HOLD_CYCLES = 4 and en = 1 -> led = 8'h20 for exactly 4 cycles, then 8'h00; busy mirrors this.
REQ-029 Push 3, 0, 7 on consecutive cycles -> led shows 8'h08, 8'h01, 8'h80 for 4 cycles each, back-to-back with no zero gap.
REQ-030 Hold en = 0 and push 5 codes with DEPTH = 4 -> in_ready drops after the 4th push, the 5th is refused, and led stays 8'h00; raise en -> exactly the 4 queued codes display in order.
REQ-031 Drop en for 3 cycles in the middle of code 2 -> led holds 8'h04 for 4 + 3 cycles total.
REQ-032 Assert rst_n = 0 mid-SHOW with 2 codes queued -> led = 0 and busy = 0 asynchronously; after release no queued code appears.
REQ-033 With CODE_DEC_SEG_EN, push codes 0..7 -> out_hex0 matches the REQ-024 table in each slot and returns to 1111111 in IDLE.
